ddr_cmd_scheduler: RTL and testbench
====================================

# ddr_cmd_scheduler

Single-requester DDR4 command scheduler that drives the DDR4 command/address pins. It accepts read/write requests with bank-group/bank/row/column, tracks the open row of each of the 16 banks, and issues PRE, ACT, RD and WR with programmed spacing. It also issues periodic all-bank refresh (PREA + REF). It sits between the memory-controller front end and the DDR4 command bus.

## Interface
- T_INIT, 8: cycles CKE held low after reset release
- T_RCD, 4: ACT to RD/WR spacing, cycles (≥2)
- T_RP, 4: PRE/PREA to ACT/REF spacing, cycles (≥2)
- T_CCD, 4: RD/WR to next scheduler action, cycles (≥2)
- T_RFC, 20: REF to next command, cycles (≥2)
- T_REFI, 200: refresh interval, cycles

- CK_t  in  1  clock, all state on rising edge
- reset_n  in  1  reset: one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  scheduler can accept
- req_we  in  1  1 = write, 0 = read
- req_bg  in  2  bank group
- req_ba  in  2  bank
- req_row  in  14  row
- req_col  in  10  column
- req_done  out  1  one-cycle pulse in the cycle RD/WR is driven
- CKE  out  1  clock enable
- cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins
- bg_addr, ba_addr  out  2 each  bank group / bank
- A17, A13, A12_BC_n, A11, A10_AP  out  1 each  address pins
- A9_A0  out  10  address pins

## Operation
- States: INIT, IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, CMD, CMD_WAIT, PREA, PREA_WAIT, REF, REF_WAIT.
- INIT: CKE=0 for T_INIT cycles, then CKE=1 and go to IDLE. The refresh timer starts on entry to IDLE.
- req_ready=1 only in IDLE with ref_pending=0. The accepted request (req_valid & req_ready) is latched.
- Per-bank table, index {bg,ba}, holds an open flag and a 14-bit row.
  - Hit (open, row equal): CMD.
  - Closed: ACT → ACT_WAIT → CMD.
  - Conflict (open, row differs): PRE → PRE_WAIT → ACT → ACT_WAIT → CMD.
- Table updates: ACT sets open and row. PRE clears the bank's open flag. PREA/REF clear all open flags.
- Refresh:
  - The timer counts T_REFI cycles, then sets sticky ref_pending and restarts.
  - A second expiry while pending is absorbed; it is not queued.
  - In IDLE, ref_pending beats req_valid. If any bank is open: PREA → PREA_WAIT → REF. Otherwise go straight to REF.
  - REF clears ref_pending. REF_WAIT is followed by IDLE.
- Command encoding, for the single command cycle (cs_n=0):
  - ACT: act_n=0, RAS_n_A16=CAS_n_A15=WE_n_A14=0, A17=0, {A13,A12_BC_n,A11,A10_AP,A9_A0}=row.
  - RD: act_n=1, RAS=1, CAS=0, WE=1, A9_A0=col, A10_AP=0, A12_BC_n=1.
  - WR: as RD but WE=0.
  - PRE: act_n=1, RAS=0, CAS=1, WE=0, A10_AP=0.
  - PREA: as PRE but A10_AP=1.
  - REF: act_n=1, RAS=0, CAS=0, WE=1.
  - bg_addr/ba_addr carry the request bank for ACT/PRE/RD/WR and 0 for PREA/REF.
- Deselect (every non-command cycle, and reset values): cs_n=1, act_n=1, RAS/CAS/WE=1, all address pins 0, bg/ba=0.
- Other reset values: req_ready=0, req_done=0, CKE=0.
- Reset mid-operation: outputs go to reset values at once, the table and ref_pending are cleared, the latched request is dropped, and the FSM returns to INIT.

## Timing
- All outputs are registered. Each command is exactly one cycle with cs_n low.
- Request accepted at edge n:
  - Hit: RD/WR in cycle n+1.
  - Closed: ACT at n+1, RD/WR at n+1+T_RCD.
  - Conflict: PRE at n+1, ACT at n+1+T_RP, RD/WR at n+1+T_RP+T_RCD.
- Wait states last T_x−1 cycles, so command-to-command spacing is exactly T_x.
- After RD/WR, CMD_WAIT lasts T_CCD−1 cycles. req_ready reasserts T_CCD cycles after RD/WR, so back-to-back hits are spaced T_CCD+1.
- Refresh with banks open: PREA at first IDLE cycle k, REF at k+T_RP, IDLE at k+T_RP+T_RFC.
- Wait counters are sized $clog2(max parameter)+1 bits. The refresh counter is $clog2(T_REFI)+1 bits.

## Test plan
- Reset, then 8 cycles CKE=0 → CKE=1 at cycle 9, req_ready=1. During reset all command pins are 1, addresses are 0, and cs_n stays 1.
- Read bg=1 ba=2 row=0x1ABC col=0x055 from closed bank → ACT (A13..A0=0x1ABC, bg=1, ba=2) at n+1; RD (A9_A0=0x055, A10=0) at n+5; req_done at n+5.
- Write, same bank, row 0x1ABC col=0x3FF → WR alone at n+1 with WE_n_A14=0. A following hit is spaced 5 cycles.
- Read, same bank, row 0x0001 → PRE (A10=0) at n+1, ACT row 0x0001 at n+5, RD at n+9.
- Hold req_valid while the timer expires with one bank open → req_ready drops, PREA (A10=1), REF 4 cycles later, req_ready returns 20 cycles after REF; the next request to that bank issues ACT first.
- Assert reset_n=0 during ACT_WAIT → outputs are deselected immediately, the RD is never issued, and after release the bench sees the INIT sequence and a closed table.

Source files
------------

// File: rtl/ddr_cmd_scheduler_if.sv
// Request handshake plus DDR4 command/address pins between the front end
// (master) and the command scheduler (slave).
interface ddr_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_bg;
    logic [1:0]  req_ba;
    logic [13:0] req_row;
    logic [9:0]  req_col;
    logic        req_done;

    logic        CKE;
    logic        cs_n;
    logic        act_n;
    logic        RAS_n_A16;
    logic        CAS_n_A15;
    logic        WE_n_A14;
    logic [1:0]  bg_addr;
    logic [1:0]  ba_addr;
    logic        A17;
    logic        A13;
    logic        A12_BC_n;
    logic        A11;
    logic        A10_AP;
    logic [9:0]  A9_A0;

    modport master (
        output req_valid, req_we, req_bg, req_ba, req_row, req_col,
        input  req_ready, req_done,
        input  CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
        input  bg_addr, ba_addr, A17, A13, A12_BC_n, A11, A10_AP, A9_A0
    );

    modport slave (
        input  req_valid, req_we, req_bg, req_ba, req_row, req_col,
        output req_ready, req_done,
        output CKE, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14,
        output bg_addr, ba_addr, A17, A13, A12_BC_n, A11, A10_AP, A9_A0
    );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// Single-requester DDR4 command scheduler: open-row tracking for 16 banks,
// PRE/ACT/RD/WR sequencing with fixed spacing, and periodic PREA+REF.
module ddr_cmd_scheduler #(
    parameter int T_INIT = 8,
    parameter int T_RCD  = 4,
    parameter int T_RP   = 4,
    parameter int T_CCD  = 4,
    parameter int T_RFC  = 20,
    parameter int T_REFI = 200
) (
    input logic                CK_t,
    input logic                reset_n,
    ddr_cmd_scheduler_if.slave bus
);
    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = imax(imax(imax(T_INIT, T_RCD), imax(T_RP, T_CCD)), T_RFC);
    localparam int CW    = $clog2(T_MAX) + 1;
    localparam int RW    = $clog2(T_REFI) + 1;

    // Wait states last T-1 cycles; the counter runs down to zero inclusive.
    localparam logic [CW-1:0] LD_INIT = CW'(T_INIT - 1);
    localparam logic [CW-1:0] LD_RCD  = CW'(T_RCD - 2);
    localparam logic [CW-1:0] LD_RP   = CW'(T_RP - 2);
    localparam logic [CW-1:0] LD_CCD  = CW'(T_CCD - 2);
    localparam logic [CW-1:0] LD_RFC  = CW'(T_RFC - 2);
    localparam logic [RW-1:0] REFI_M1 = RW'(T_REFI - 1);

    typedef enum logic [3:0] {
        INIT, IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT,
        CMD, CMD_WAIT, PREA, PREA_WAIT, REF, REF_WAIT
    } state_e;

    typedef enum logic [2:0] {C_ACT, C_RD, C_WR, C_PRE, C_PREA, C_REF} cmd_e;

    typedef struct packed {
        logic       cs_n;
        logic       act_n;
        logic       ras_n;
        logic       cas_n;
        logic       we_n;
        logic [1:0] bg;
        logic [1:0] ba;
        logic       a17;
        logic       a13;
        logic       a12;
        logic       a11;
        logic       a10;
        logic [9:0] a9_0;
    } pins_t;

    typedef struct packed {
        logic        we;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] row;
        logic [9:0]  col;
    } req_t;

    localparam pins_t DESEL = pins_t'(24'hF8_0000);

    function automatic pins_t mk_cmd(cmd_e k, logic [1:0] bg, logic [1:0] ba,
                                     logic [13:0] row, logic [9:0] col);
        pins_t p;
        p      = DESEL;
        p.cs_n = 1'b0;
        case (k)
            C_ACT: begin
                p.act_n = 1'b0;
                p.ras_n = 1'b0;
                p.cas_n = 1'b0;
                p.we_n  = 1'b0;
                p.bg    = bg;
                p.ba    = ba;
                {p.a13, p.a12, p.a11, p.a10, p.a9_0} = row;
            end
            C_RD, C_WR: begin
                p.cas_n = 1'b0;
                p.we_n  = (k == C_RD);
                p.bg    = bg;
                p.ba    = ba;
                p.a12   = 1'b1;
                p.a9_0  = col;
            end
            C_PRE: begin
                p.ras_n = 1'b0;
                p.we_n  = 1'b0;
                p.bg    = bg;
                p.ba    = ba;
            end
            C_PREA: begin
                p.ras_n = 1'b0;
                p.we_n  = 1'b0;
                p.a10   = 1'b1;
            end
            default: begin
                p.ras_n = 1'b0;
                p.cas_n = 1'b0;
            end
        endcase
        return p;
    endfunction

    state_e            state;
    logic [CW-1:0]     wcnt;
    logic [RW-1:0]     ref_cnt;
    logic              ref_en;
    logic              ref_pending;
    logic              ref_expire;
    logic              ref_issue;
    logic              pend_nxt;
    logic [15:0]       bank_open;
    logic [15:0][13:0] bank_row;
    req_t              req_q;
    req_t              req_in;
    pins_t             pins;
    logic              cke_q;
    logic              ready_q;
    logic              done_q;
    logic [3:0]        idx_in;
    logic [3:0]        idx_q;
    logic              hit;

    assign req_in = {bus.req_we, bus.req_bg, bus.req_ba, bus.req_row, bus.req_col};
    assign idx_in = {req_in.bg, req_in.ba};
    assign idx_q  = {req_q.bg, req_q.ba};
    assign hit    = bank_open[idx_in] && (bank_row[idx_in] == req_in.row);

    // REF is driven on the edge that leaves IDLE (no open banks) or PREA_WAIT.
    assign ref_expire = ref_en && (ref_cnt == REFI_M1);
    assign ref_issue  = ((state == IDLE) && ref_pending && (bank_open == '0)) ||
                        ((state == PREA_WAIT) && (wcnt == '0));
    assign pend_nxt   = ref_expire || (ref_pending && !ref_issue);

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            ref_en      <= 1'b0;
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_pending <= pend_nxt;
            if ((state == INIT) && (wcnt == '0)) ref_en <= 1'b1;
            if (!ref_en || ref_expire) ref_cnt <= '0;
            else                       ref_cnt <= ref_cnt + 1'b1;
        end
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            wcnt      <= LD_INIT;
            pins      <= DESEL;
            cke_q     <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            bank_open <= '0;
            bank_row  <= '0;
            req_q     <= '0;
        end else begin
            pins    <= DESEL;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            case (state)
                INIT: begin
                    if (wcnt == '0) begin
                        state   <= IDLE;
                        cke_q   <= 1'b1;
                        ready_q <= !pend_nxt;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (ref_pending) begin
                        if (bank_open != '0) begin
                            state <= PREA;
                            pins  <= mk_cmd(C_PREA, 2'd0, 2'd0, 14'd0, 10'd0);
                        end else begin
                            state <= REF;
                            pins  <= mk_cmd(C_REF, 2'd0, 2'd0, 14'd0, 10'd0);
                        end
                        bank_open <= '0;
                    end else if (bus.req_valid && ready_q) begin
                        req_q <= req_in;
                        if (hit) begin
                            state  <= CMD;
                            done_q <= 1'b1;
                            pins   <= mk_cmd(req_in.we ? C_WR : C_RD, req_in.bg, req_in.ba,
                                             req_in.row, req_in.col);
                        end else if (!bank_open[idx_in]) begin
                            state              <= ACT;
                            bank_open[idx_in]  <= 1'b1;
                            bank_row[idx_in]   <= req_in.row;
                            pins <= mk_cmd(C_ACT, req_in.bg, req_in.ba, req_in.row, req_in.col);
                        end else begin
                            state             <= PRE;
                            bank_open[idx_in] <= 1'b0;
                            pins <= mk_cmd(C_PRE, req_in.bg, req_in.ba, req_in.row, req_in.col);
                        end
                    end else begin
                        ready_q <= !pend_nxt;
                    end
                end
                PRE: begin
                    state <= PRE_WAIT;
                    wcnt  <= LD_RP;
                end
                PRE_WAIT: begin
                    if (wcnt == '0) begin
                        state            <= ACT;
                        bank_open[idx_q] <= 1'b1;
                        bank_row[idx_q]  <= req_q.row;
                        pins <= mk_cmd(C_ACT, req_q.bg, req_q.ba, req_q.row, req_q.col);
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                ACT: begin
                    state <= ACT_WAIT;
                    wcnt  <= LD_RCD;
                end
                ACT_WAIT: begin
                    if (wcnt == '0) begin
                        state  <= CMD;
                        done_q <= 1'b1;
                        pins   <= mk_cmd(req_q.we ? C_WR : C_RD, req_q.bg, req_q.ba,
                                         req_q.row, req_q.col);
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                CMD: begin
                    state <= CMD_WAIT;
                    wcnt  <= LD_CCD;
                end
                CMD_WAIT: begin
                    if (wcnt == '0) begin
                        state   <= IDLE;
                        ready_q <= !pend_nxt;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                PREA: begin
                    state <= PREA_WAIT;
                    wcnt  <= LD_RP;
                end
                PREA_WAIT: begin
                    if (wcnt == '0) begin
                        state <= REF;
                        pins  <= mk_cmd(C_REF, 2'd0, 2'd0, 14'd0, 10'd0);
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                REF: begin
                    state <= REF_WAIT;
                    wcnt  <= LD_RFC;
                end
                REF_WAIT: begin
                    if (wcnt == '0) begin
                        state   <= IDLE;
                        ready_q <= !pend_nxt;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.req_done  = done_q;
    assign bus.CKE       = cke_q;
    assign bus.cs_n      = pins.cs_n;
    assign bus.act_n     = pins.act_n;
    assign bus.RAS_n_A16 = pins.ras_n;
    assign bus.CAS_n_A15 = pins.cas_n;
    assign bus.WE_n_A14  = pins.we_n;
    assign bus.bg_addr   = pins.bg;
    assign bus.ba_addr   = pins.ba;
    assign bus.A17       = pins.a17;
    assign bus.A13       = pins.a13;
    assign bus.A12_BC_n  = pins.a12;
    assign bus.A11       = pins.a11;
    assign bus.A10_AP    = pins.a10;
    assign bus.A9_A0     = pins.a9_0;
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Bench for ddr_cmd_scheduler: a schedule model predicts every output pin per
// cycle from timing rules; directed steps then random traffic.
module tb_ddr_cmd_scheduler;
    localparam int T_INIT = 8;
    localparam int T_RCD  = 4;
    localparam int T_RP   = 4;
    localparam int T_CCD  = 4;
    localparam int T_RFC  = 20;
    localparam int T_REFI = 200;

    logic CK_t    = 1'b0;
    logic reset_n = 1'b0;

    ddr_cmd_scheduler_if bus();

    ddr_cmd_scheduler #(
        .T_INIT(T_INIT), .T_RCD(T_RCD), .T_RP(T_RP),
        .T_CCD(T_CCD), .T_RFC(T_RFC), .T_REFI(T_REFI)
    ) dut (
        .CK_t   (CK_t),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 CK_t = ~CK_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: expected command per cycle, done pulses, bank table, refresh state.
    logic [23:0] sched   [int];
    bit          done_at [int];
    logic [26:0] obs_log [int];
    bit          m_open  [16];
    logic [13:0] m_row   [16];
    int          busy;
    int          ref_clr;
    bit          pend;
    bit          accepted;

    function automatic logic [23:0] pv(bit cs, bit act, bit ras, bit cas, bit we,
                                       logic [1:0] bg, logic [1:0] ba, bit a17, bit a13,
                                       bit a12, bit a11, bit a10, logic [9:0] a9);
        return {cs, act, ras, cas, we, bg, ba, a17, a13, a12, a11, a10, a9};
    endfunction

    function automatic logic [23:0] e_des();
        return pv(1, 1, 1, 1, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 10'd0);
    endfunction
    function automatic logic [23:0] e_act(logic [1:0] bg, logic [1:0] ba, logic [13:0] row);
        return pv(0, 0, 0, 0, 0, bg, ba, 0, row[13], row[12], row[11], row[10], row[9:0]);
    endfunction
    function automatic logic [23:0] e_rw(bit we, logic [1:0] bg, logic [1:0] ba, logic [9:0] col);
        return pv(0, 1, 1, 0, !we, bg, ba, 0, 0, 1, 0, 0, col);
    endfunction
    function automatic logic [23:0] e_pre(logic [1:0] bg, logic [1:0] ba);
        return pv(0, 1, 0, 1, 0, bg, ba, 0, 0, 0, 0, 0, 10'd0);
    endfunction
    function automatic logic [23:0] e_prea();
        return pv(0, 1, 0, 1, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1, 10'd0);
    endfunction
    function automatic logic [23:0] e_ref();
        return pv(0, 1, 0, 0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 10'd0);
    endfunction

    function automatic logic [26:0] get_obs();
        return {bus.CKE, bus.req_ready, bus.req_done, bus.cs_n, bus.act_n, bus.RAS_n_A16,
                bus.CAS_n_A15, bus.WE_n_A14, bus.bg_addr, bus.ba_addr, bus.A17, bus.A13,
                bus.A12_BC_n, bus.A11, bus.A10_AP, bus.A9_A0};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sched.delete();
        done_at.delete();
        for (int i = 0; i < 16; i++) begin
            m_open[i] = 0;
            m_row[i]  = '0;
        end
        busy     = T_INIT;
        ref_clr  = -1;
        pend     = 0;
        accepted = 0;
        cyc      = 0;
    endtask

    // Predict what the edge that starts cycle e does, from the inputs now driven.
    task automatic model_edge(int e);
        accepted = 0;
        if (e - 1 >= busy) begin
            if (pend) begin
                int rc;
                bit any;
                any = 0;
                for (int i = 0; i < 16; i++) any |= m_open[i];
                if (any) begin
                    sched[e] = e_prea();
                    rc = e + T_RP;
                end else begin
                    rc = e;
                end
                sched[rc] = e_ref();
                for (int i = 0; i < 16; i++) m_open[i] = 0;
                busy    = rc + T_RFC;
                ref_clr = rc;
            end else if (bus.req_valid) begin
                int b;
                int t;
                b = int'({bus.req_bg, bus.req_ba});
                t = e;
                accepted = 1;
                if (m_open[b] && m_row[b] != bus.req_row) begin
                    sched[t] = e_pre(bus.req_bg, bus.req_ba);
                    t += T_RP;
                    m_open[b] = 0;
                end
                if (!m_open[b]) begin
                    sched[t] = e_act(bus.req_bg, bus.req_ba, bus.req_row);
                    t += T_RCD;
                    m_open[b] = 1;
                    m_row[b]  = bus.req_row;
                end
                sched[t]   = e_rw(bus.req_we, bus.req_bg, bus.req_ba, bus.req_col);
                done_at[t] = 1;
                busy       = t + T_CCD;
            end
        end
        if (e == ref_clr) pend = 0;
        if (e > T_INIT && (e - T_INIT) % T_REFI == 0) pend = 1;
    endtask

    task automatic check_cycle(int c);
        logic [26:0] obs;
        logic [26:0] exp;
        bit          rdy;
        bit          dn;
        logic [23:0] p;
        obs = get_obs();
        rdy = (c >= busy) && !pend;
        dn  = done_at.exists(c) != 0;
        p   = (sched.exists(c) != 0) ? sched[c] : e_des();
        exp = {(c >= T_INIT), rdy, dn, p};
        obs_log[c] = obs;
        chk($sformatf("cycle%0d", c), obs, exp);
    endtask

    task automatic tick();
        model_edge(cyc + 1);
        @(negedge CK_t);
        cyc++;
        check_cycle(cyc);
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(bit we, logic [1:0] bg, logic [1:0] ba, logic [13:0] row,
                        logic [9:0] col, output int n);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_bg    = bg;
        bus.req_ba    = ba;
        bus.req_row   = row;
        bus.req_col   = col;
        n = -1;
        for (int i = 0; i < 2000 && n < 0; i++) begin
            tick();
            if (accepted) n = cyc;
        end
        bus.req_valid = 1'b0;
        chk("send_accepted", (n >= 0), 1);
    endtask

    initial begin
        int n;
        int n2;
        int e;
        int a;
        logic [13:0] rrow;
        bit conf;

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_bg    = '0;
        bus.req_ba    = '0;
        bus.req_row   = '0;
        bus.req_col   = '0;
        model_reset();

        // Reset held: everything deselected, CKE low.
        repeat (3) @(negedge CK_t);
        chk("rst_outputs", get_obs(), {3'b000, e_des()});
        reset_n = 1'b1;
        check_cycle(0);
        run(T_INIT + 2);
        chk("cke_low_init", obs_log[T_INIT - 1][26], 0);
        chk("cke_high", obs_log[T_INIT][26], 1);
        chk("ready_after_init", obs_log[T_INIT][25], 1);

        // Closed bank read.
        send(0, 2'd1, 2'd2, 14'h1ABC, 10'h055, n);
        run(12);
        chk("closed_act", obs_log[n][23:0], e_act(2'd1, 2'd2, 14'h1ABC));
        chk("closed_rd", obs_log[n + T_RCD][23:0], e_rw(0, 2'd1, 2'd2, 10'h055));
        chk("closed_done", obs_log[n + T_RCD][24], 1);

        // Hit write, then back-to-back hit.
        send(1, 2'd1, 2'd2, 14'h1ABC, 10'h3FF, n);
        send(0, 2'd1, 2'd2, 14'h1ABC, 10'h100, n2);
        run(10);
        chk("hit_wr", obs_log[n][23:0], e_rw(1, 2'd1, 2'd2, 10'h3FF));
        chk("hit_spacing", n2 - n, T_CCD + 1);

        // Row conflict.
        send(0, 2'd1, 2'd2, 14'h0001, 10'h010, n);
        run(16);
        chk("conf_pre", obs_log[n][23:0], e_pre(2'd1, 2'd2));
        chk("conf_act", obs_log[n + T_RP][23:0], e_act(2'd1, 2'd2, 14'h0001));
        chk("conf_rd", obs_log[n + T_RP + T_RCD][23:0], e_rw(0, 2'd1, 2'd2, 10'h010));

        // Refresh with one bank open while a request waits.
        for (int i = 0; i < 400 && !pend; i++) tick();
        chk("ref_pending_seen", pend, 1);
        e = cyc;
        send(0, 2'd1, 2'd2, 14'h0001, 10'h020, n);
        run(8);
        chk("ref_ready_drop", obs_log[e][25], 0);
        chk("ref_prea", obs_log[e + 1][23:0], e_prea());
        chk("ref_ref", obs_log[e + 1 + T_RP][23:0], e_ref());
        chk("ref_ready_low", obs_log[e + T_RP + T_RFC][25], 0);
        chk("ref_ready_back", obs_log[e + 1 + T_RP + T_RFC][25], 1);
        chk("ref_accept_edge", n, e + 2 + T_RP + T_RFC);
        chk("ref_then_act", obs_log[n][23:0], e_act(2'd1, 2'd2, 14'h0001));

        // Random traffic over a few banks and rows; refreshes interleave.
        for (int k = 0; k < 150; k++) begin
            logic [1:0]  bg;
            logic [1:0]  ba;
            logic [13:0] row;
            bg  = 2'($urandom_range(0, 1));
            ba  = 2'($urandom_range(0, 3));
            row = ($urandom_range(0, 3) == 0) ? 14'($urandom) : 14'($urandom_range(0, 2));
            send(1'($urandom_range(0, 1)), bg, ba, row, 10'($urandom), n);
            run($urandom_range(0, 4));
        end
        run(30);

        // Reset during ACT_WAIT.
        conf = m_open[11];
        rrow = m_open[11] ? (m_row[11] + 14'd1) : 14'h0005;
        send(0, 2'd2, 2'd3, rrow, 10'h02A, n);
        a = conf ? (n + T_RP) : n;
        run(a + 1 - cyc);
        reset_n = 1'b0;
        #1;
        chk("midrst_outputs", get_obs(), {3'b000, e_des()});
        for (int i = 0; i < 2 * T_RCD; i++) begin
            @(negedge CK_t);
            chk("midrst_hold", get_obs(), {3'b000, e_des()});
        end
        model_reset();
        reset_n = 1'b1;
        check_cycle(0);
        run(T_INIT + 2);
        chk("midrst_cke_low", obs_log[T_INIT - 1][26], 0);
        chk("midrst_cke_high", obs_log[T_INIT][26], 1);
        send(0, 2'd2, 2'd3, rrow, 10'h02A, n);
        run(10);
        chk("midrst_act", obs_log[n][23:0], e_act(2'd2, 2'd3, rrow));
        chk("midrst_rd", obs_log[n + T_RCD][23:0], e_rw(0, 2'd2, 2'd3, 10'h02A));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
